// File: rtl/respondedor_de_bus.sv
// rtl/respondedor_de_bus.sv - bus responder serving RAM, output ports, input port and access counter
module respondedor_de_bus #(
    parameter int WAIT_CYCLES = 1               // wait states between capture and acknowledge, 0..15
) (
    input  logic       clk,                     // system clock
    input  logic       rst,                     // synchronous active-high reset
    input  logic       i_Req,                   // transfer request, held until o_Ack
    input  logic [7:0] i_Addressdata,           // transfer address
    input  logic [7:0] i_Dataout,               // write data
    input  logic       i_ReadWrite,             // 1 = write, 0 = read
    input  logic [7:0] i_Port_In,               // asynchronous board input pins
    output logic       o_Ack,                   // one-cycle acknowledge
    output logic [7:0] o_Datain,                // read data, valid with o_Ack
    output logic       o_Err,                   // error flag, valid with o_Ack
    output logic [7:0] o_Port_A,                // output port A register
    output logic [7:0] o_Port_B                 // output port B register
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_REL} state_t;

    state_t     state, state_nxt;
    logic [7:0] addr_q, data_q;
    logic       rw_q;
    logic [3:0] wait_cnt;
    logic [7:0] ram [16];
    logic [7:0] sync1, sync2;
    logic [7:0] acc_cnt;

    logic       is_ram, is_port, mapped, read_only, access_err, finish;
    logic [7:0] rd_data;

    // Decode of the latched transfer; only consulted on the WAIT->ACK edge.
    always_comb begin
        is_ram     = (addr_q[7:4] == 4'h0);
        is_port    = (addr_q[7:2] == 6'b100000);
        mapped     = is_ram || is_port;
        read_only  = is_port && addr_q[1];
        access_err = !mapped || (rw_q && read_only);
        finish     = (state == ST_WAIT) && (wait_cnt == 4'd0);
        rd_data    = 8'h00;
        if (is_ram) begin
            rd_data = ram[addr_q[3:0]];
        end else if (is_port) begin
            case (addr_q[1:0])
                2'd0:    rd_data = o_Port_A;
                2'd1:    rd_data = o_Port_B;
                2'd2:    rd_data = sync2;
                default: rd_data = acc_cnt;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        o_Ack     = 1'b0;
        case (state)
            ST_IDLE: if (i_Req) state_nxt = ST_WAIT;
            ST_WAIT: if (wait_cnt == 4'd0) state_nxt = ST_ACK;
            ST_ACK: begin
                o_Ack     = 1'b1;
                state_nxt = ST_REL;
            end
            default: if (!i_Req) state_nxt = ST_IDLE;
        endcase
    end

    // Reset lands in REL so a request left high across reset must be released first.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_REL;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
            rw_q     <= 1'b0;
            wait_cnt <= 4'd0;
            sync1    <= 8'h00;
            sync2    <= 8'h00;
            acc_cnt  <= 8'h00;
            o_Datain <= 8'h00;
            o_Err    <= 1'b0;
            o_Port_A <= 8'h00;
            o_Port_B <= 8'h00;
            for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
        end else begin
            sync1 <= i_Port_In;
            sync2 <= sync1;
            if (state == ST_IDLE && i_Req) begin
                addr_q   <= i_Addressdata;
                data_q   <= i_Dataout;
                rw_q     <= i_ReadWrite;
                wait_cnt <= 4'(WAIT_CYCLES);
            end
            if (state == ST_WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
            if (finish) begin
                // A read of the counter returns acc_cnt before this increment.
                o_Datain <= rd_data;
                o_Err    <= access_err;
                if (!access_err) acc_cnt <= acc_cnt + 8'd1;
                if (rw_q && !access_err) begin
                    if (is_ram)                    ram[addr_q[3:0]] <= data_q;
                    else if (addr_q[1:0] == 2'd0)  o_Port_A         <= data_q;
                    else                           o_Port_B         <= data_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_respondedor_de_bus.sv
// tb/tb_respondedor_de_bus.sv - randomized self-checking bench for respondedor_de_bus
module tb_respondedor_de_bus;

    localparam int W = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_Req;
    logic [7:0] i_Addressdata, i_Dataout, i_Port_In;
    logic       i_ReadWrite;
    logic       o_Ack, o_Err;
    logic [7:0] o_Datain, o_Port_A, o_Port_B;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram_m [16];
    logic [7:0] pa_m, pb_m, pins_m, cnt_m;

    respondedor_de_bus #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .i_Req(i_Req), .i_Addressdata(i_Addressdata),
        .i_Dataout(i_Dataout), .i_ReadWrite(i_ReadWrite), .i_Port_In(i_Port_In),
        .o_Ack(o_Ack), .o_Datain(o_Datain), .o_Err(o_Err),
        .o_Port_A(o_Port_A), .o_Port_B(o_Port_B)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ram_m[i] = 8'h00;
        pa_m  = 8'h00;
        pb_m  = 8'h00;
        cnt_m = 8'h00;
    endtask

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        if (a < 8'h10)   return ram_m[a[3:0]];
        if (a == 8'h80)  return pa_m;
        if (a == 8'h81)  return pb_m;
        if (a == 8'h82)  return pins_m;
        if (a == 8'h83)  return cnt_m;
        return 8'h00;
    endfunction

    task automatic xfer(input logic rw, input logic [7:0] a, input logic [7:0] d);
        logic       mapped, err;
        logic [7:0] exp_rd;
        int         k;
        logic       got;
        mapped = (a < 8'h10) || (a >= 8'h80 && a <= 8'h83);
        err    = !mapped || (rw && (a == 8'h82 || a == 8'h83));
        exp_rd = model_rd(a);

        @(negedge clk);
        i_Req = 1'b1; i_Addressdata = a; i_Dataout = d; i_ReadWrite = rw;
        @(posedge clk);
        #1;
        i_Addressdata = ~a; i_Dataout = ~d; i_ReadWrite = ~rw;
        k = 0; got = 1'b0;
        while (k < 20 && !got) begin
            @(posedge clk); #1;
            k++;
            if (o_Ack) got = 1'b1;
        end
        check("ack_latency", k, W + 1);
        check("err", o_Err, err);
        if (!rw || !mapped) check("datain", o_Datain, exp_rd);

        if (!err) begin
            cnt_m = cnt_m + 8'd1;
            if (rw) begin
                if (a < 8'h10)      ram_m[a[3:0]] = d;
                else if (a == 8'h80) pa_m = d;
                else                 pb_m = d;
            end
        end
        check("port_a", o_Port_A, pa_m);
        check("port_b", o_Port_B, pb_m);

        i_Req = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", o_Ack, 1'b0);
        @(posedge clk);
    endtask

    task automatic set_pins(input logic [7:0] v);
        @(negedge clk);
        i_Port_In = v;
        repeat (3) @(posedge clk);
        pins_m = v;
    endtask

    initial begin
        logic       seen;
        logic [7:0] a;
        rst = 1'b1; i_Req = 1'b1; i_Addressdata = 8'h03; i_Dataout = 8'h00;
        i_ReadWrite = 1'b0; i_Port_In = 8'h00; pins_m = 8'h00;
        model_reset();

        // reset with request held high
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", o_Ack, 1'b0);
        check("rst_datain", o_Datain, 8'h00);
        check("rst_err", o_Err, 1'b0);
        check("rst_port_a", o_Port_A, 8'h00);
        check("rst_port_b", o_Port_B, 8'h00);
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (o_Ack) seen = 1'b1; end
        check("no_ack_held_req", seen, 1'b0);
        @(negedge clk); i_Req = 1'b0;
        @(posedge clk);

        // directed cases
        xfer(1'b1, 8'h03, 8'h5A);
        xfer(1'b0, 8'h03, 8'h00);
        xfer(1'b1, 8'h80, 8'hA5);
        xfer(1'b0, 8'h80, 8'h00);
        xfer(1'b0, 8'h40, 8'h00);
        xfer(1'b1, 8'h82, 8'h11);
        xfer(1'b0, 8'h83, 8'h00);
        set_pins(8'h3C);
        xfer(1'b0, 8'h82, 8'h00);

        // reset in WAIT of a write to 0x05
        @(negedge clk);
        i_Req = 1'b1; i_Addressdata = 8'h05; i_Dataout = 8'h77; i_ReadWrite = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("abort_ack", o_Ack, 1'b0);
        model_reset();
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (o_Ack) seen = 1'b1; end
        check("abort_no_ack", seen, 1'b0);
        @(negedge clk); i_Req = 1'b0;
        @(posedge clk);
        xfer(1'b0, 8'h05, 8'h00);
        xfer(1'b0, 8'h83, 8'h00);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 4))
                0, 1:    a = 8'($urandom_range(0, 15));
                2:       a = 8'h80 + 8'($urandom_range(0, 3));
                3:       a = 8'h10 + 8'($urandom_range(0, 8'h6F));
                default: a = 8'h84 + 8'($urandom_range(0, 8'h7B));
            endcase
            if ($urandom_range(0, 9) == 0) set_pins(8'($urandom));
            xfer(1'($urandom), a, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
